// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the core (C)
// and a loader/debug DMA port (D), with optional D burst locking.
module dmem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {OWN_C, OWN_D} owner_t;

  state_t        state;
  owner_t        last_owner;
  logic [BW-1:0] burst_cnt;

  logic          d_locked;
  logic          pick_d;
  logic          any_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
    return (v >= BURST_CAP) ? BURST_CAP : v + BW'(1);
  endfunction

  // Arbitration (IDLE cycle): a locked D keeps the memory until the burst cap is hit.
  always_comb begin
    any_req  = c_req | d_req;
    d_locked = (last_owner == OWN_D) && d_lock && (burst_cnt != '0);
    pick_d   = 1'b0;
    if (d_req && !c_req)
      pick_d = 1'b1;
    else if (d_req && c_req)
      pick_d = (d_locked && (burst_cnt < BURST_CAP)) ? 1'b1 : (last_owner == OWN_C);
    sel_we    = pick_d ? d_we    : c_we;
    sel_addr  = pick_d ? d_addr  : c_addr;
    sel_wdata = pick_d ? d_wdata : c_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= OWN_D;
      burst_cnt  <= '0;
      c_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      c_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      c_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            // Grant stage: register the winner's access toward the memory.
            state      <= ACCESS;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_read   <= ~sel_we;
            mem_write  <= sel_we;
            c_gnt      <= ~pick_d;
            d_gnt      <= pick_d;
            last_owner <= pick_d ? OWN_D : OWN_C;
            if (pick_d)
              burst_cnt <= d_lock ? sat_inc(burst_cnt) : '0;
            else
              burst_cnt <= '0;
          end
        end
        ACCESS: begin
          // Access stage: read data returns to the owner of this cycle.
          state <= IDLE;
          if (mem_read) begin
            if (last_owner == OWN_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              c_rdata  <= mem_rdata;
              c_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural memory and a grant scoreboard.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  dmem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_c_rdata, exp_d_rdata;
  int          checks, errors;
  int          w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.is_d  = is_d;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    if (we) ref_mem[addr] = wdata;
    e.rdata = (!we && ref_mem.exists(addr)) ? ref_mem[addr] : 32'h0;
    exp_q.push_back(e);
  endtask

  // Waits for the next grant, checks it against the scoreboard head, then checks the
  // following cycle (pulse widths, rvalid and read data).
  task automatic access_check(input string tag, input bit drop_c, input bit drop_d,
                              output int waited);
    exp_t e;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(c_gnt || d_gnt) && waited < 20);
    if (!(c_gnt || d_gnt)) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: no grant after %0d cycles, expected one", tag, waited);
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_extra: grant observed, none expected", tag);
      return;
    end
    e = exp_q.pop_front();
    if (drop_c) c_req = 1'b0;
    if (drop_d) d_req = 1'b0;
    chkb({tag, "_d_gnt"}, d_gnt, e.is_d);
    chkb({tag, "_c_gnt"}, c_gnt, !e.is_d);
    chkb({tag, "_mem_read"}, mem_read, !e.we);
    chkb({tag, "_mem_write"}, mem_write, e.we);
    chk({tag, "_mem_addr"}, mem_addr, e.addr);
    if (e.we) chk({tag, "_mem_wdata"}, mem_wdata, e.wdata);
    tick();
    chkb({tag, "_gnt_pulse"}, c_gnt | d_gnt, 1'b0);
    chkb({tag, "_rw_pulse"}, mem_read | mem_write, 1'b0);
    if (!e.we) begin
      if (e.is_d) exp_d_rdata = e.rdata;
      else        exp_c_rdata = e.rdata;
    end
    chkb({tag, "_c_rvalid"}, c_rvalid, !e.we && !e.is_d);
    chkb({tag, "_d_rvalid"}, d_rvalid, !e.we && e.is_d);
    chk({tag, "_c_rdata"}, c_rdata, exp_c_rdata);
    chk({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_c_rdata = '0;
    exp_d_rdata = '0;
    rst_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chkb("rst_c_gnt", c_gnt, 1'b0);
    chkb("rst_d_gnt", d_gnt, 1'b0);
    chkb("rst_c_rvalid", c_rvalid, 1'b0);
    chkb("rst_d_rvalid", d_rvalid, 1'b0);
    chkb("rst_mem_read", mem_read, 1'b0);
    chkb("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // D preloads 0x10, then C reads it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    push_exp(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    access_check("d_wr_10", 1'b0, 1'b1, w);
    chk("d_wr_10_latency", w, 1);

    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    push_exp(1'b0, 1'b0, 32'h10, 32'h0);
    access_check("c_rd_10", 1'b1, 1'b0, w);
    chk("c_rd_10_latency", w, 1);

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    push_exp(1'b1, 1'b1, 32'h20, 32'h12345678);
    access_check("d_wr_20", 1'b0, 1'b1, w);

    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    access_check("d_rd_20", 1'b0, 1'b1, w);

    // Both request continuously without lock: C,D,C,D one grant every two cycles.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_lock = 1'b0;
    push_exp(1'b0, 1'b0, 32'h20, 32'h0);
    push_exp(1'b1, 1'b0, 32'h10, 32'h0);
    push_exp(1'b0, 1'b0, 32'h20, 32'h0);
    push_exp(1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      access_check("alt", i == 3, i == 3, w);
      chk("alt_latency", w, 1);
    end

    // C request withdrawn before the edge: only D is granted.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    #3;
    c_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    access_check("c_drop", 1'b0, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkb("c_drop_no_c_gnt", c_gnt, 1'b0);
      chkb("c_drop_no_d_gnt", d_gnt, 1'b0);
    end

    // Locked D burst: D alone first, then C joins; expect D,D,D,D,C.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_lock = 1'b1;
    push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    access_check("burst_first", 1'b0, 1'b0, w);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    push_exp(1'b0, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      access_check("burst", i == 3, i == 3, w);
      chk("burst_latency", w, 1);
    end
    d_lock = 1'b0;

    // C writes 0x30; a D write to 0x30 is then cut short by reset.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hCAFEF00D;
    push_exp(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
    access_check("c_wr_30", 1'b1, 1'b0, w);

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h0BADBEEF;
    w = 0;
    do begin
      tick();
      w++;
    end while (!d_gnt && w < 20);
    chkb("rst_mid_d_gnt", d_gnt, 1'b1);
    chkb("rst_mid_mem_write_before", mem_write, 1'b1);
    d_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chkb("rst_mid_mem_write_drop", mem_write, 1'b0);
    chkb("rst_mid_mem_read_drop", mem_read, 1'b0);
    chkb("rst_mid_d_gnt_drop", d_gnt, 1'b0);
    tick();
    chkb("rst_mid_no_d_rvalid", d_rvalid, 1'b0);
    rst_n = 1'b1;
    exp_c_rdata = '0;
    exp_d_rdata = '0;

    // After reset a tie goes to C; 0x30 still holds C's data.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    push_exp(1'b0, 1'b0, 32'h30, 32'h0);
    push_exp(1'b1, 1'b0, 32'h30, 32'h0);
    access_check("post_rst_c", 1'b1, 1'b0, w);
    chk("post_rst_c_latency", w, 1);
    access_check("post_rst_d", 1'b0, 1'b1, w);
    chk("post_rst_d_latency", w, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
